// File: rtl/gbe_status_pkg.sv
// ----------------------------------------------------------------------------
// gbe_status_pkg
//   Shared definitions for the 10GbE TX status monitor:
//   - bit positions of every field in the packed 32-bit status word
//   - the frame-tracking FSM state type
// ----------------------------------------------------------------------------
package gbe_status_pkg;

  // Status word field positions
  localparam int LINK_BIT   = 31;
  localparam int OVF_BIT    = 30;
  localparam int AFULL_BIT  = 29;
  localparam int LENERR_BIT = 28;
  localparam int LDCNT_MSB  = 27;
  localparam int LDCNT_LSB  = 24;
  localparam int HB_BIT     = 23;
  localparam int FCNT_MSB   = 15;
  localparam int FCNT_LSB   = 0;

  // Frame tracker states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_FRAME = 2'd1,
    DROP     = 2'd2
  } frame_state_e;

endpackage : gbe_status_pkg

// File: rtl/gbe_frame_tracker.sv
// ----------------------------------------------------------------------------
// gbe_frame_tracker
//   Follows TX frames word by word and flags the outcome of each frame.
//   A frame that reaches MAX_FRAME_WORDS words without tx_eof is a length
//   error; the rest of it is discarded up to and including its tx_eof.
//
// Ports
//   user_clk    in  clock
//   user_rst_n  in  asynchronous active-low reset (FSM -> IDLE, wlen -> 0)
//   tx_valid    in  data word accepted this cycle
//   tx_eof      in  end of frame, qualified by tx_valid
//   frame_ok    out one-cycle pulse: a frame of legal length completed
//   len_err     out one-cycle pulse: a frame hit the length limit
//
// Both outputs are combinational from the current state and inputs, so the
// event lands in the parent's registers on the same edge the word is sampled.
// ----------------------------------------------------------------------------
module gbe_frame_tracker
  import gbe_status_pkg::*;
#(
  parameter int MAX_FRAME_WORDS = 1024
) (
  input  logic user_clk,
  input  logic user_rst_n,
  input  logic tx_valid,
  input  logic tx_eof,
  output logic frame_ok,
  output logic len_err
);

  localparam int WLEN_W = $clog2(MAX_FRAME_WORDS + 1);
  // One extra bit so the incremented length can be compared without wrap.
  localparam logic [WLEN_W:0] MAX_WORDS = (WLEN_W + 1)'(MAX_FRAME_WORDS);

  frame_state_e      state_q, state_d;
  logic [WLEN_W-1:0] wlen_q, wlen_d;
  logic [WLEN_W:0]   wlen_inc;

  assign wlen_inc = {1'b0, wlen_q} + (WLEN_W + 1)'(1);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    wlen_d   = wlen_q;
    frame_ok = 1'b0;
    len_err  = 1'b0;
    if (tx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (tx_eof) begin
            frame_ok = 1'b1;
          end else begin
            wlen_d  = WLEN_W'(1);
            state_d = IN_FRAME;
          end
        end
        IN_FRAME: begin
          wlen_d = wlen_inc[WLEN_W-1:0];
          if (tx_eof) begin
            frame_ok = (wlen_inc <= MAX_WORDS);
            wlen_d   = '0;
            state_d  = IDLE;
          end else if (wlen_inc == MAX_WORDS) begin
            len_err = 1'b1;
            wlen_d  = '0;
            state_d = DROP;
          end
        end
        DROP: begin
          if (tx_eof) state_d = IDLE;
        end
        default: begin
          wlen_d  = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q <= IDLE;
      wlen_q  <= '0;
    end else begin
      state_q <= state_d;
      wlen_q  <= wlen_d;
    end
  end

endmodule : gbe_frame_tracker

// File: rtl/gbe_tx_status_monitor.sv
// ----------------------------------------------------------------------------
// gbe_tx_status_monitor
//   Collects live and sticky 10GbE TX status in the user_clk domain and packs
//   it into a 32-bit word for the software status register.
//
// Ports
//   user_clk     in   sole clock
//   user_rst_n   in   asynchronous active-low reset
//   tx_valid     in   TX word accepted this cycle
//   tx_eof       in   end of frame, qualified by tx_valid
//   tx_overflow  in   TX buffer overflow level   -> sticky [30]
//   tx_afull     in   TX buffer almost-full level -> sticky [29]
//   link_up      in   PHY link level -> live [31], falls counted in [27:24]
//   ctrl_clr     in   software clear level; only its rising edge clears
//   status_word  out  {link, ovf, afull, lenerr, ldcnt[3:0], hb, 7'b0, fcnt[15:0]}
//
// Build option
//   GBE_STATUS_HEARTBEAT_EN : when defined, bit [23] toggles every
//   HEARTBEAT_CYCLES cycles; otherwise bit [23] is constant 0.
//
// status_word is driven only by registers; a clear pulse overrides any
// counter increment or sticky set from the same cycle.
// ----------------------------------------------------------------------------
module gbe_tx_status_monitor
  import gbe_status_pkg::*;
#(
  parameter int MAX_FRAME_WORDS  = 1024,
  parameter int HEARTBEAT_CYCLES = 2**27
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic        tx_valid,
  input  logic        tx_eof,
  input  logic        tx_overflow,
  input  logic        tx_afull,
  input  logic        link_up,
  input  logic        ctrl_clr,
  output logic [31:0] status_word
);

  logic        frame_ok, len_err;
  logic        clr_pulse, link_fall;

  logic        ctrl_clr_q, ctrl_clr_d;
  logic        link_q,     link_d;
  logic        ovf_q,      ovf_d;
  logic        afull_q,    afull_d;
  logic        lenerr_q,   lenerr_d;
  logic [3:0]  ldcnt_q,    ldcnt_d;
  logic [15:0] fcnt_q,     fcnt_d;
  logic        hb;

  gbe_frame_tracker #(
    .MAX_FRAME_WORDS (MAX_FRAME_WORDS)
  ) u_frame_tracker (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .tx_valid   (tx_valid),
    .tx_eof     (tx_eof),
    .frame_ok   (frame_ok),
    .len_err    (len_err)
  );

  // link_q doubles as the previous link level; reset makes it 0, so a link
  // that is already down at reset release is not counted as a fall.
  assign clr_pulse = ctrl_clr & ~ctrl_clr_q;
  assign link_fall = link_q & ~link_up;

  always_comb begin
    ctrl_clr_d = ctrl_clr;
    link_d     = link_up;
    if (clr_pulse) begin
      ovf_d    = 1'b0;
      afull_d  = 1'b0;
      lenerr_d = 1'b0;
      ldcnt_d  = '0;
      fcnt_d   = '0;
    end else begin
      ovf_d    = ovf_q    | tx_overflow;
      afull_d  = afull_q  | tx_afull;
      lenerr_d = lenerr_q | len_err;
      ldcnt_d  = (link_fall && ldcnt_q != 4'hF) ? ldcnt_q + 4'd1 : ldcnt_q;
      fcnt_d   = fcnt_q + 16'(frame_ok);
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ctrl_clr_q <= 1'b0;
      link_q     <= 1'b0;
      ovf_q      <= 1'b0;
      afull_q    <= 1'b0;
      lenerr_q   <= 1'b0;
      ldcnt_q    <= '0;
      fcnt_q     <= '0;
    end else begin
      ctrl_clr_q <= ctrl_clr_d;
      link_q     <= link_d;
      ovf_q      <= ovf_d;
      afull_q    <= afull_d;
      lenerr_q   <= lenerr_d;
      ldcnt_q    <= ldcnt_d;
      fcnt_q     <= fcnt_d;
    end
  end

`ifdef GBE_STATUS_HEARTBEAT_EN
  localparam int HB_W = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);

  logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
  logic            hb_q, hb_d;

  // Free-running: software clear must not disturb the clock-alive indicator.
  always_comb begin
    hb_cnt_d = hb_cnt_q + HB_W'(1);
    hb_d     = hb_q;
    if (hb_cnt_q == HB_LAST) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
    end
  end

  assign hb = hb_q;
`else
  assign hb = 1'b0;
`endif

  always_comb begin
    status_word                       = '0;
    status_word[LINK_BIT]             = link_q;
    status_word[OVF_BIT]              = ovf_q;
    status_word[AFULL_BIT]            = afull_q;
    status_word[LENERR_BIT]           = lenerr_q;
    status_word[LDCNT_MSB:LDCNT_LSB]  = ldcnt_q;
    status_word[HB_BIT]               = hb;
    status_word[FCNT_MSB:FCNT_LSB]    = fcnt_q;
  end

endmodule : gbe_tx_status_monitor
